// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard and forwarding controller for the in-order pipeline.
// Tracks in-flight destinations after ID, issues registered EX forwarding
// selects, raises load-use stalls and branch flushes, and counts both events.
module pipe_hazard_unit #(
    parameter int  REG_ADDR_W = 5,
    parameter int  NUM_STAGES = 3,
    parameter int  LOAD_STAGE = 2,
    parameter int  CNT_W      = 16,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [SEL_W-1:0]      ex_fwd_rs1_sel,
    output logic [SEL_W-1:0]      ex_fwd_rs2_sel,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    // One scoreboard slot per stage after ID; slot 1 is the instruction in EX.
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    entry_t sb [1:NUM_STAGES];

    logic [SEL_W-1:0] rs1_sel_d;
    logic [SEL_W-1:0] rs2_sel_d;
    logic             rs1_load_hit;
    logic             rs2_load_hit;
    logic             load_use;
    logic             id_advance;

    // Find the youngest producer for each source operand and whether it is an
    // unforwardable load. Scanning oldest to youngest lets the youngest win.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        rs1_sel_d    = '0;
        rs2_sel_d    = '0;
        rs1_load_hit = 1'b0;
        rs2_load_hit = 1'b0;
        for (int k = NUM_STAGES; k >= 1; k--) begin
            if (sb[k].valid && sb[k].reg_write && (sb[k].rd != '0)) begin
                if (id_use_rs1 && (id_rs1 != '0) && (id_rs1 == sb[k].rd)) begin
                    rs1_sel_d    = SEL_W'(k);
                    rs1_load_hit = sb[k].is_load && (k < LOAD_STAGE);
                end
                if (id_use_rs2 && (id_rs2 != '0) && (id_rs2 == sb[k].rd)) begin
                    rs2_sel_d    = SEL_W'(k);
                    rs2_load_hit = sb[k].is_load && (k < LOAD_STAGE);
                end
            end
        end
    end

    // A taken branch squashes the ID instruction, so it overrides a load-use
    // stall; reset silences all control outputs without waiting for an edge.
    assign load_use    = id_valid && (rs1_load_hit || rs2_load_hit);
    assign stall       = load_use && !ex_branch_taken && !reset;
    assign flush_if_id = ex_branch_taken && !reset;
    assign flush_id_ex = ex_branch_taken && !reset;
    assign id_advance  = id_valid && !stall && !ex_branch_taken;

    // Shift the scoreboard one stage per cycle; slot 1 takes the ID
    // instruction when it advances and a bubble otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the scoreboard is a handful of flops whose valid bits must
            // be clear out of reset, so every entry is reset, not just a pointer.
            for (int k = 1; k <= NUM_STAGES; k++) begin
                sb[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every slot read its
            // neighbour's old value, which is what makes this a shift register.
            for (int k = NUM_STAGES; k >= 2; k--) begin
                sb[k] <= sb[k-1];
            end
            if (id_advance) begin
                sb[1] <= '{valid: 1'b1, reg_write: id_reg_write,
                           is_load: id_is_load, rd: id_rd};
            end else begin
                sb[1] <= '0;
            end
        end
    end

    // Register the forwarding selects into EX; a bubble carries select 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_fwd_rs1_sel <= '0;
            ex_fwd_rs2_sel <= '0;
        end else if (id_advance) begin
            ex_fwd_rs1_sel <= rs1_sel_d;
            ex_fwd_rs2_sel <= rs2_sel_d;
        end else begin
            ex_fwd_rs1_sel <= '0;
            ex_fwd_rs2_sel <= '0;
        end
    end

    // Saturating event counters for stall cycles and taken branches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (ex_branch_taken && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: directed checks of forwarding, load-use stall, branch
// flush, counter saturation and asynchronous reset.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       ex_branch_taken;

    logic        stall, flush_if_id, flush_id_ex;
    logic [1:0]  rs1_sel, rs2_sel;
    logic [15:0] stall_count, flush_count;

    logic        s_stall, s_flush_if_id, s_flush_id_ex;
    logic [1:0]  s_rs1_sel, s_rs2_sel;
    logic [1:0]  s_stall_count, s_flush_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .ex_fwd_rs1_sel  (rs1_sel),
        .ex_fwd_rs2_sel  (rs2_sel),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    pipe_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_is_load      (id_is_load),
        .ex_branch_taken (ex_branch_taken),
        .stall           (s_stall),
        .flush_if_id     (s_flush_if_id),
        .flush_id_ex     (s_flush_id_ex),
        .ex_fwd_rs1_sel  (s_rs1_sel),
        .ex_fwd_rs2_sel  (s_rs2_sel),
        .stall_count     (s_stall_count),
        .flush_count     (s_flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one ID instruction and let the combinational outputs settle.
    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        #1;
    endtask

    task automatic nop();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Producer of r, gap nops, then a consumer reading r on rs2.
    task automatic fwd_seq(input int gap, input logic [4:0] r, input int exp_sel);
        drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, r, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < gap; i++) begin
            nop();
            tick();
        end
        drive(1'b1, 5'd1, r, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        check($sformatf("gap%0d_stall", gap), 32'(stall), 0);
        tick();
        nop();
        check($sformatf("gap%0d_rs2_sel", gap), 32'(rs2_sel), exp_sel);
        check($sformatf("gap%0d_rs1_sel", gap), 32'(rs1_sel), 0);
    endtask

    initial begin
        reset           = 1'b1;
        ex_branch_taken = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("rst_stall", 32'(stall), 0);
        check("rst_flush_if_id", 32'(flush_if_id), 0);
        check("rst_flush_id_ex", 32'(flush_id_ex), 0);
        check("rst_rs1_sel", 32'(rs1_sel), 0);
        check("rst_rs2_sel", 32'(rs2_sel), 0);
        check("rst_stall_count", 32'(stall_count), 0);
        check("rst_flush_count", 32'(flush_count), 0);
        tick();
        tick();
        reset = 1'b0;

        // Back-to-back dependency forwards from EX/MEM (select 1), no stall.
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        check("t1_prod_stall", 32'(stall), 0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        check("t1_cons_stall", 32'(stall), 0);
        tick();
        nop();
        check("t1_rs1_sel", 32'(rs1_sel), 1);
        check("t1_rs2_sel", 32'(rs2_sel), 0);

        // Select follows producer distance and drops to 0 once it leaves.
        fwd_seq(0, 5'd10, 1);
        fwd_seq(1, 5'd11, 2);
        fwd_seq(2, 5'd12, 3);
        fwd_seq(3, 5'd13, 0);

        // Writes to x0 and reads of x0 never forward.
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
        check("t4_x0_stall", 32'(stall), 0);
        tick();
        nop();
        check("t4_x0_rs1_sel", 32'(rs1_sel), 0);
        check("t4_x0_rs2_sel", 32'(rs2_sel), 0);

        // A non-writing instruction is not a producer.
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd14, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd14, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
        tick();
        nop();
        check("t4_nowrite_sel", 32'(rs1_sel), 0);

        // An invalid ID slot does not enter the scoreboard.
        drive(1'b0, 5'd1, 5'd0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd16, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        nop();
        check("t4_invalid_sel", 32'(rs1_sel), 0);

        // Same register written at distances 1 and 2: the youngest wins.
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd15, 5'd15, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        nop();
        check("t4_prio_rs1_sel", 32'(rs1_sel), 1);
        check("t4_prio_rs2_sel", 32'(rs2_sel), 1);

        // An operand the instruction does not read is not forwarded.
        drive(1'b1, 5'd15, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
        tick();
        nop();
        check("t4_unused_sel", 32'(rs1_sel), 0);

        // Load-use: one stall cycle, then forwarding from distance 2.
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd20, 1'b1, 1'b1);
        check("t3_load_stall", 32'(stall), 0);
        tick();
        drive(1'b1, 5'd20, 5'd20, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check("t3_stall_on", 32'(stall), 1);
        check("t3_count_before", 32'(stall_count), 0);
        tick();
        check("t3_stall_off", 32'(stall), 0);
        check("t3_count_after", 32'(stall_count), 1);
        check("t3_bubble_rs1_sel", 32'(rs1_sel), 0);
        check("t3_bubble_rs2_sel", 32'(rs2_sel), 0);
        tick();
        nop();
        check("t3_rs1_sel", 32'(rs1_sel), 2);
        check("t3_rs2_sel", 32'(rs2_sel), 2);
        check("t3_nop_stall", 32'(stall), 0);

        // Taken branch during a load-use hazard: flush wins over stall.
        tick();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd21, 1'b1, 1'b1);
        tick();
        ex_branch_taken = 1'b1;
        drive(1'b1, 5'd21, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check("t5_stall", 32'(stall), 0);
        check("t5_flush_if_id", 32'(flush_if_id), 1);
        check("t5_flush_id_ex", 32'(flush_id_ex), 1);
        tick();
        ex_branch_taken = 1'b0;
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0);
        check("t5_flush_count", 32'(flush_count), 1);
        check("t5_stall_count", 32'(stall_count), 1);
        check("t5_rs1_sel", 32'(rs1_sel), 0);
        check("t5_rs2_sel", 32'(rs2_sel), 0);
        check("t5_flush_clear", 32'(flush_if_id), 0);
        tick();
        nop();
        check("t5_squashed_sel", 32'(rs1_sel), 0);

        // Counter saturation: five load-use stalls on a 2-bit counter.
        reset = 1'b1;
        #1;
        check("t6_rst_count", 32'(stall_count), 0);
        check("t6_rst_flush_count", 32'(flush_count), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd22, 1'b1, 1'b1);
            tick();
            drive(1'b1, 5'd22, 5'd22, 1'b1, 1'b1, 5'd24, 1'b1, 1'b0);
            check($sformatf("t6_stall_on%0d", i), 32'(stall), 1);
            tick();
            check($sformatf("t6_stall_off%0d", i), 32'(stall), 0);
            tick();
        end
        nop();
        check("t6_sat_count", 32'(s_stall_count), 3);
        check("t6_wide_count", 32'(stall_count), 5);

        // Asynchronous reset in the middle of a stall cycle.
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd23, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd23, 5'd0, 1'b1, 1'b0, 5'd25, 1'b1, 1'b1);
        check("t6_alu_load_stall", 32'(stall), 0);
        tick();
        drive(1'b1, 5'd25, 5'd0, 1'b1, 1'b0, 5'd26, 1'b1, 1'b0);
        check("t6_pre_stall", 32'(stall), 1);
        check("t6_pre_rs1_sel", 32'(rs1_sel), 1);
        reset = 1'b1;
        #1;
        check("t6_async_stall", 32'(stall), 0);
        check("t6_async_rs1_sel", 32'(rs1_sel), 0);
        check("t6_async_count", 32'(stall_count), 0);
        check("t6_async_sat_count", 32'(s_stall_count), 0);
        ex_branch_taken = 1'b1;
        #1;
        check("t6_async_flush_if_id", 32'(flush_if_id), 0);
        check("t6_async_flush_id_ex", 32'(flush_id_ex), 0);
        ex_branch_taken = 1'b0;
        reset = 1'b0;
        #1;
        check("t6_post_stall", 32'(stall), 0);
        tick();
        nop();
        check("t6_post_rs1_sel", 32'(rs1_sel), 0);
        check("t6_post_count", 32'(stall_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
